serial_deserializer: RTL and testbench
======================================

// Module: serial_deserializer
// PURPOSE
//   Parametrised serial-to-parallel converter with framing and output handshake.
//   - Collects WIDTH qualified serial bits into a word, in a selectable bit order.
//   - Presents each word through a one-entry valid/ready holding register.
//   - Supports resync on a frame marker and flags dropped words.
//   - Sits between a serial line front-end and word-oriented consumers (FIFO, decoder).
// PARAMETERS
//   WIDTH      8   word width in bits; legal range 2..64
//   MSB_FIRST  0   0: first received bit lands in dout[0]; 1: first bit lands in dout[WIDTH-1]
//   CNT_W      $clog2(WIDTH)   localparam, width of the bit counter
// PORTS
//   clk         in   1      rising-edge clock; the only clock
//   reset       in   1      asynchronous, active-low reset (0 = reset asserted)
//   din         in   1      serial data bit
//   din_valid   in   1      din is sampled only when this is 1
//   sync        in   1      frame marker; restarts word assembly
//   dout        out  WIDTH  assembled word; held stable while dout_valid=1
//   dout_valid  out  1      dout holds an unconsumed word
//   dout_ready  in   1      consumer accepts dout when dout_valid && dout_ready
//   bit_cnt     out  CNT_W  number of bits of the current partial word received
//   overflow    out  1      sticky flag: a completed word was dropped
//   clr_ovf     in   1      synchronous clear of overflow
// BEHAVIOUR
//   - Reset (reset=0, async): shift register, dout, dout_valid, bit_cnt, overflow all 0.
//   - Accept: on a clk edge with din_valid=1, shift din into the shift register and increment bit_cnt.
//     - MSB_FIRST=0: shift right, inserting din at bit WIDTH-1.
//     - MSB_FIRST=1: shift left, inserting din at bit 0.
//   - Completion: the edge that accepts the bit with bit_cnt==WIDTH-1 completes the word.
//     - bit_cnt wraps to 0 on that edge.
//     - Completed word = shift register contents plus that bit, per the insertion rule above.
//   - Load: on completion, if the holding register is free (dout_valid=0, or dout_ready=1 this cycle),
//     dout is loaded with the completed word and dout_valid=1 on the same edge.
//     - Latency: last bit sampled at edge N -> dout valid after edge N.
//   - Handshake: on an edge with dout_valid && dout_ready and no completion, dout_valid -> 0 and dout holds.
//     - Simultaneous consume and completion: new word loaded, dout_valid stays 1, no overflow.
//   - Overflow: completion while dout_valid=1 and dout_ready=0.
//     - Completed word is discarded; dout is unchanged; overflow -> 1.
//     - Assembly of the next word continues normally.
//   - clr_ovf=1 clears overflow on the next edge. A new overflow on the same edge wins (overflow stays 1).
//   - sync=1 && din_valid=1: partial word discarded; din is accepted as bit 0 of a new word (bit_cnt -> 1).
//     - WIDTH=... completion is impossible on this edge.
//   - sync=1 && din_valid=0: bit_cnt -> 0; shift contents are don't-care.
//   - din_valid=0 and sync=0: shift register and bit_cnt hold.
//   - Reset mid-word or with dout pending: everything discarded immediately; no partial word is emitted.
//   - dout, dout_valid, bit_cnt and overflow are all registered outputs; there are no combinational input-to-output paths.
// STRUCTURE
//   - Shared package deser_pkg:
//     - bit-order constants DESER_LSB_FIRST=0, DESER_MSB_FIRST=1;
//     - function clog2_min1 (returns at least 1) used to size CNT_W.
//   - One sub-module, deser_shift_core: WIDTH shift register + bit counter + sync handling.
//     - Emits word_done and word_data.
//   - Top level owns the holding register, the handshake and overflow.
// TESTING
//   - Reset: hold reset=0 with random din/din_valid -> all outputs 0.
//     Release reset; dout_valid stays 0 until 8 valid bits are sent.
//   - Bit order: WIDTH=8, MSB_FIRST=0, bits 1,0,1,1,0,0,1,0 (first to last) with dout_ready=1
//     -> dout=8'h4D, dout_valid=1 one edge after the 8th bit.
//     Same stream with MSB_FIRST=1 -> dout=8'hB2.
//   - Gapped input: same stream with din_valid=0 on alternate cycles -> identical words.
//     bit_cnt increments only on valid cycles.
//   - Backpressure: dout_ready=0, send two words 8'hA5 then 8'h3C -> dout stays 8'hA5, overflow=1.
//     Pulse clr_ovf -> overflow=0. Raise dout_ready -> dout_valid=0 next edge.
//   - Back-to-back with consume: complete 8'h3C on the same edge dout_ready=1 consumes 8'hA5
//     -> dout=8'h3C, dout_valid=1, overflow=0.
//   - Sync/reset mid-word: 5 bits, then sync with din_valid=1 and 7 more bits -> bit_cnt resets to 1;
//     the word is formed from the last 8 bits only.
//     Assert reset after 4 bits -> no word is emitted; bit_cnt=0.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared definitions for the serial deserializer: bit-order
// selectors and counter sizing helper.
package deser_pkg;

    localparam int DESER_LSB_FIRST = 0;
    localparam int DESER_MSB_FIRST = 1;

    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/deser_shift_core.sv
// Serial shift register and bit counter with frame resync.
// Flags completion of each WIDTH-bit word combinationally.
module deser_shift_core
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = DESER_LSB_FIRST,
    parameter int CNT_W     = clog2_min1(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_i,
    input  logic             din_valid_i,
    input  logic             sync_i,
    output logic             word_done_o,
    output logic [WIDTH-1:0] word_data_o,
    output logic [CNT_W-1:0] bit_cnt_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d, shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    generate
        if (MSB_FIRST == DESER_MSB_FIRST) begin : g_msb
            assign shifted = {sr_q[WIDTH-2:0], din_i};
        end else begin : g_lsb
            assign shifted = {din_i, sr_q[WIDTH-1:1]};
        end
    endgenerate

    // A sync bit always starts a fresh word, so it can never complete one.
    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        word_done_o = 1'b0;
        if (din_valid_i) begin
            sr_d = shifted;
            if (sync_i) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q == LAST) begin
                cnt_d       = '0;
                word_done_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (sync_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign word_data_o = shifted;
    assign bit_cnt_o   = cnt_q;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel converter: one-entry valid/ready holding
// register on top of the shift core, with sticky drop flag.
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = DESER_LSB_FIRST,
    localparam int CNT_W    = clog2_min1(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overflow,
    input  logic             clr_ovf
);

    logic             word_done;
    logic [WIDTH-1:0] word_data;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             slot_free;

    deser_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .din_i       (din),
        .din_valid_i (din_valid),
        .sync_i      (sync),
        .word_done_o (word_done),
        .word_data_o (word_data),
        .bit_cnt_o   (bit_cnt)
    );

    assign slot_free = !valid_q || dout_ready;

    // A fresh overflow outranks a clear on the same edge.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        ovf_d   = clr_ovf ? 1'b0 : ovf_q;
        if (word_done) begin
            if (slot_free) begin
                dout_d  = word_data;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer, LSB-first and
// MSB-first instances driven by the same serial stream.
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       sync = 1'b0;
    logic       dout_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] dout, dout_m;
    logic       dout_valid, dout_valid_m;
    logic [2:0] bit_cnt, bit_cnt_m;
    logic       overflow, overflow_m;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] pat = 8'h4D;

    always #5 clk = ~clk;

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .sync(sync), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .bit_cnt(bit_cnt),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .sync(sync), .dout(dout_m), .dout_valid(dout_valid_m),
        .dout_ready(dout_ready), .bit_cnt(bit_cnt_m),
        .overflow(overflow_m), .clr_ovf(clr_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        din = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_bit(w[i]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        dout_ready = 1'b0;
        clr_ovf = 1'b0;
        sync = 1'b0;
        din_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            din = 1'($urandom_range(0, 1));
            din_valid = 1'($urandom_range(0, 1));
            tick();
        end
        din_valid = 1'b0;
        n_cmp++;
        if ({dout, dout_valid, bit_cnt, overflow} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_lsb: got dout=%h v=%b cnt=%0d ovf=%b, want all 0",
                     dout, dout_valid, bit_cnt, overflow);
        end
        n_cmp++;
        if ({dout_m, dout_valid_m, bit_cnt_m, overflow_m} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_msb: got dout=%h v=%b cnt=%0d ovf=%b, want all 0",
                     dout_m, dout_valid_m, bit_cnt_m, overflow_m);
        end
        reset = 1'b1;
        tick();
        send_bits(pat, 0, 6);
        n_cmp++;
        if (dout_valid !== 1'b0 || bit_cnt !== 3'd7) begin
            n_err++;
            $display("FAIL reset_7bits: got v=%b cnt=%0d, want v=0 cnt=7",
                     dout_valid, bit_cnt);
        end
    endtask

    task automatic test_bit_order();
        do_reset();
        dout_ready = 1'b1;
        send_bits(pat, 0, 6);
        n_cmp++;
        if (dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL order_early: got v=%b, want 0", dout_valid);
        end
        send_bit(pat[7]);
        n_cmp++;
        if (dout_valid !== 1'b1 || dout !== 8'h4D) begin
            n_err++;
            $display("FAIL order_lsb: got v=%b dout=%h, want v=1 dout=4d",
                     dout_valid, dout);
        end
        n_cmp++;
        if (dout_valid_m !== 1'b1 || dout_m !== 8'hB2) begin
            n_err++;
            $display("FAIL order_msb: got v=%b dout=%h, want v=1 dout=b2",
                     dout_valid_m, dout_m);
        end
        tick();
        n_cmp++;
        if (dout_valid !== 1'b0 || dout !== 8'h4D) begin
            n_err++;
            $display("FAIL order_consume: got v=%b dout=%h, want v=0 dout=4d",
                     dout_valid, dout);
        end
    endtask

    task automatic test_gapped();
        logic [2:0] exp_cnt;
        do_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_bit(pat[i]);
            exp_cnt = 3'((i + 1) % 8);
            n_cmp++;
            if (bit_cnt !== exp_cnt) begin
                n_err++;
                $display("FAIL gap_cnt%0d: got %0d, want %0d", i, bit_cnt, exp_cnt);
            end
            if (i == 7) begin
                n_cmp++;
                if (dout !== 8'h4D || dout_m !== 8'hB2 || dout_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL gap_word: got lsb=%h msb=%h v=%b, want 4d b2 1",
                             dout, dout_m, dout_valid);
                end
            end
            tick();
            n_cmp++;
            if (bit_cnt !== exp_cnt) begin
                n_err++;
                $display("FAIL gap_hold%0d: got %0d, want %0d", i, bit_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] w2;
        w2 = 8'h3C;
        do_reset();
        send_bits(8'hA5, 0, 7);
        n_cmp++;
        if (dout_valid !== 1'b1 || dout !== 8'hA5 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL bp_first: got v=%b dout=%h ovf=%b, want 1 a5 0",
                     dout_valid, dout, overflow);
        end
        send_bits(w2, 0, 7);
        n_cmp++;
        if (dout_valid !== 1'b1 || dout !== 8'hA5 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL bp_drop: got v=%b dout=%h ovf=%b, want 1 a5 1",
                     dout_valid, dout, overflow);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL bp_clear: got ovf=%b, want 0", overflow);
        end
        send_bits(w2, 0, 6);
        clr_ovf = 1'b1;
        send_bit(w2[7]);
        clr_ovf = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1 || dout !== 8'hA5) begin
            n_err++;
            $display("FAIL bp_set_wins: got ovf=%b dout=%h, want 1 a5",
                     overflow, dout);
        end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        n_cmp++;
        if (dout_valid !== 1'b0 || dout !== 8'hA5) begin
            n_err++;
            $display("FAIL bp_release: got v=%b dout=%h, want 0 a5",
                     dout_valid, dout);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w2;
        w2 = 8'h3C;
        do_reset();
        send_bits(8'hA5, 0, 7);
        send_bits(w2, 0, 6);
        dout_ready = 1'b1;
        send_bit(w2[7]);
        dout_ready = 1'b0;
        n_cmp++;
        if (dout !== 8'h3C || dout_valid !== 1'b1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL b2b: got dout=%h v=%b ovf=%b, want 3c 1 0",
                     dout, dout_valid, overflow);
        end
        tick();
        n_cmp++;
        if (dout_valid !== 1'b1 || dout !== 8'h3C) begin
            n_err++;
            $display("FAIL b2b_hold: got v=%b dout=%h, want 1 3c", dout_valid, dout);
        end
    endtask

    task automatic test_sync_reset();
        logic [7:0] w;
        w = 8'h96;
        do_reset();
        dout_ready = 1'b1;
        send_bits(8'hFF, 0, 4);
        n_cmp++;
        if (bit_cnt !== 3'd5) begin
            n_err++;
            $display("FAIL sync_pre: got cnt=%0d, want 5", bit_cnt);
        end
        sync = 1'b1;
        send_bit(w[0]);
        sync = 1'b0;
        n_cmp++;
        if (bit_cnt !== 3'd1 || dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sync_restart: got cnt=%0d v=%b, want 1 0", bit_cnt, dout_valid);
        end
        send_bits(w, 1, 7);
        n_cmp++;
        if (dout !== 8'h96 || dout_valid !== 1'b1 || bit_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL sync_word: got dout=%h v=%b cnt=%0d, want 96 1 0",
                     dout, dout_valid, bit_cnt);
        end
        send_bits(8'h00, 0, 2);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        n_cmp++;
        if (bit_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL sync_idle: got cnt=%0d, want 0", bit_cnt);
        end
        send_bits(8'hFF, 0, 3);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bit_cnt !== 3'd0 || dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got cnt=%0d v=%b, want 0 0", bit_cnt, dout_valid);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (bit_cnt !== 3'd0 || dout_valid !== 1'b0 || dout !== 8'h00) begin
            n_err++;
            $display("FAIL reset_noemit: got cnt=%0d v=%b dout=%h, want 0 0 00",
                     bit_cnt, dout_valid, dout);
        end
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_gapped();
        test_backpressure();
        test_back_to_back();
        test_sync_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
